aes_round_sequencer: RTL and testbench

- Next-state controller and round counter for the AES-128 encrypt/decrypt datapath.
- Produces the 4-bit state code Q consumed by the existing state-to-control decoder, which drives LOAD/tri_*/ENB/LOOP.
- Handles the start/done/ack handshake with the host and supports abort.
- Sits between the host interface and the decoder; the datapath itself is unchanged.

---
 rtl/aes_round_sequencer.sv | 139 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: state code Q and round counter for the datapath decoder.
// Optional AES_SEQ_STALL_EN adds a stall input that freezes Q/round in S1..S7.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       out_ack,
  input  logic       abort,
`ifdef AES_SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic [3:0] Q,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       mode_q
);

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd6;
  localparam logic [3:0] S7 = 4'd7;
  localparam logic [3:0] S8 = 4'd8;
  localparam logic [3:0] S9 = 4'd9;

  localparam logic [3:0] RLAST = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] RMAX  = 4'(NUM_ROUNDS);

  logic [3:0] q, q_n;
  logic [3:0] rnd, rnd_n;
  logic       done_q, done_n;
  logic       mq, mq_n;
  logic       in_hold, nx_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= S0;
      rnd    <= 4'd0;
      done_q <= 1'b0;
      mq     <= 1'b0;
    end else begin
      q      <= q_n;
      rnd    <= rnd_n;
      done_q <= done_n;
      mq     <= mq_n;
    end
  end

  always_comb begin
    q_n   = q;
    rnd_n = rnd;
    mq_n  = mq;
    case (q)
      S0: begin
        rnd_n = 4'd0;
        if (start) begin
          mq_n = mode;
          q_n  = mode ? S4 : S1;
        end
      end
      S1: begin
        q_n   = S2;
        rnd_n = 4'd1;
      end
      S2: begin
        if (rnd >= RLAST) begin
          q_n   = S3;
          rnd_n = RMAX;
        end else begin
          rnd_n = rnd + 4'd1;
        end
      end
      S3: q_n = S8;
      S4: begin
        q_n   = S5;
        rnd_n = 4'd1;
      end
      S5: begin
        q_n   = S6;
        rnd_n = 4'd2;
      end
      S6: begin
        if (rnd >= RLAST) begin
          q_n   = S7;
          rnd_n = RMAX;
        end else begin
          rnd_n = rnd + 4'd1;
        end
      end
      S7: q_n = S9;
      S8, S9: begin
        if (out_ack) begin
          rnd_n = 4'd0;
          q_n   = S0;
          // back-to-back: skip the idle cycle
          if (start) begin
            mq_n = mode;
            q_n  = mode ? S4 : S1;
          end
        end
      end
      default: begin
        q_n   = S0;
        rnd_n = 4'd0;
      end
    endcase
`ifdef AES_SEQ_STALL_EN
    if (stall && busy) begin
      q_n   = q;
      rnd_n = rnd;
    end
`endif
    if (abort) begin
      q_n   = S0;
      rnd_n = 4'd0;
      mq_n  = mq;
    end
  end

  assign in_hold = (q == S8) || (q == S9);
  assign nx_hold = (q_n == S8) || (q_n == S9);
  assign done_n  = nx_hold && !in_hold;

  always_comb begin
    Q      = q;
    round  = rnd;
    done   = done_q;
    mode_q = mq;
    busy   = (q >= S1) && (q <= S7);
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer (NUM_ROUNDS=10).
module tb_aes_round_sequencer;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       b;
    logic       d;
    logic       m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, mode, out_ack, abort, stall;
  logic [3:0] q, round;
  logic       busy, done, mode_q;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .out_ack(out_ack),
    .abort(abort),
`ifdef AES_SEQ_STALL_EN
    .stall(stall),
`endif
    .Q(q),
    .round(round),
    .busy(busy),
    .done(done),
    .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int sq, int r, bit d, bit m);
    exp_t e;
    e.q = 4'(sq);
    e.r = 4'(r);
    e.b = (sq >= 1) && (sq <= 7);
    e.d = d;
    e.m = m;
    return e;
  endfunction

  // hand-derived trajectories, k = cycles after start was driven
  function automatic exp_t enc_e(int k);
    if (k == 1) return mk(1, 0, 0, 0);
    if (k <= 10) return mk(2, k - 1, 0, 0);
    if (k == 11) return mk(3, 10, 0, 0);
    if (k == 12) return mk(8, 10, 1, 0);
    return mk(8, 10, 0, 0);
  endfunction

  function automatic exp_t dec_e(int k);
    if (k == 1) return mk(4, 0, 0, 1);
    if (k == 2) return mk(5, 1, 0, 1);
    if (k <= 10) return mk(6, k - 1, 0, 1);
    if (k == 11) return mk(7, 10, 0, 1);
    if (k == 12) return mk(9, 10, 1, 1);
    return mk(9, 10, 0, 1);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{q: q, r: round, b: busy, d: done, m: mode_q};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb t=%0t: got Q=%0d round=%0d busy=%0b done=%0b mode_q=%0b want Q=%0d round=%0d busy=%0b done=%0b mode_q=%0b",
                 $time, a.q, a.r, a.b, a.d, a.m, e.q, e.r, e.b, e.d, e.m);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int b = 0;
    while (exp_q.size() > 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d entries pending, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic ack_to_idle(input int sq, input bit m);
    exp_q.push_back(mk(sq, 10, 0, m));
    exp_q.push_back(mk(0, 0, 0, m));
    out_ack = 1'b1;
    cyc(1);
    out_ack = 1'b0;
    drain("ack");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    out_ack = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    cyc(2);
    chk("reset", {q, round, 5'(busy), 3'(done)}, 16'h0000);
    chk("reset_mode", 16'(mode_q), 16'h0000);
    rst = 1'b0;
    cyc(1);

    // encrypt
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 1; k <= 13; k++) exp_q.push_back(enc_e(k));
    start = 1'b1;
    mode = 1'b0;
    cyc(1);
    start = 1'b0;
    drain("enc");
    ack_to_idle(8, 0);

    // decrypt with ignored start/out_ack mid-run
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 1; k <= 13; k++) exp_q.push_back(dec_e(k));
    start = 1'b1;
    mode = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    start = 1'b1;
    mode = 1'b0;
    out_ack = 1'b1;
    cyc(1);
    start = 1'b0;
    out_ack = 1'b0;
    drain("dec");
    ack_to_idle(9, 1);

    // back-to-back encrypt -> decrypt
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int k = 1; k <= 13; k++) exp_q.push_back(enc_e(k));
    start = 1'b1;
    mode = 1'b0;
    cyc(1);
    start = 1'b0;
    drain("b2b_enc");
    exp_q.push_back(mk(8, 10, 0, 0));
    for (int k = 1; k <= 13; k++) exp_q.push_back(dec_e(k));
    out_ack = 1'b1;
    start = 1'b1;
    mode = 1'b1;
    cyc(1);
    out_ack = 1'b0;
    start = 1'b0;
    drain("b2b_dec");
    ack_to_idle(9, 1);

    // abort at Q=6 round=5
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int k = 1; k <= 6; k++) exp_q.push_back(dec_e(k));
    start = 1'b1;
    mode = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 1));
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    drain("abort");

    // abort + start in S0
    exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 1));
    abort = 1'b1;
    start = 1'b1;
    mode = 1'b0;
    cyc(1);
    abort = 1'b0;
    start = 1'b0;
    drain("abort_s0");

    // reset at Q=2
    exp_q.push_back(mk(0, 0, 0, 1));
    for (int k = 1; k <= 4; k++) exp_q.push_back(enc_e(k));
    start = 1'b1;
    mode = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(3);
    exp_q.push_back(mk(0, 0, 0, 0));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    drain("rst_mid");

    // illegal state code
    force dut.q = 4'hC;
    cyc(1);
    release dut.q;
    cyc(1);
    chk("illegal", {q, round, 5'(busy), 3'(done)}, 16'h0000);

`ifdef AES_SEQ_STALL_EN
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      if (k <= 5) exp_q.push_back(enc_e(k));
      else if (k <= 8) exp_q.push_back(enc_e(5));
      else exp_q.push_back(enc_e(k - 3));
    end
    start = 1'b1;
    mode = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(4);
    stall = 1'b1;
    cyc(3);
    stall = 1'b0;
    drain("stall");
    ack_to_idle(8, 0);
`endif

    cyc(2);
    chk("sb_empty", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
